// File: rtl/cpu_pkg.sv
// Shared state encoding and opcode-field helpers for the accumulator CPU sequencer.
package cpu_pkg;

  typedef enum logic [3:0] {
    FETCH0, FETCH1, FETCHD, DECODE, PTR0, PTR1,
    RD0, RD1, WR0, WR1, EXEC, HALT
  } seq_state_t;

  // Opcode bit 7 (inst[15]) marks a two-byte instruction.
  localparam logic [7:0] ONE_ARG  = 8'h80;
  localparam int         SRC_LSB  = 9;
  localparam logic [1:0] SRC_DATA = 2'b01;

  function automatic logic is_two_byte(input logic [7:0] opc);
    return (opc & ONE_ARG) != 8'h00;
  endfunction

  // Source-data forms carry one more byte after the argument byte.
  function automatic logic has_data_byte(input logic [15:0] ins);
    return (ins[15:14] == 2'b10) && (ins[SRC_LSB+1:SRC_LSB] == SRC_DATA);
  endfunction

endpackage

// File: rtl/cpu_mem_port.sv
// Byte-wide memory port: issues a request while i_start is high and freezes we/addr/wdata until ack.
// No added latency (ack in the first cycle completes it); the caller stalls until o_done.
module cpu_mem_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic        o_done,
  output logic [7:0]  o_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_ack
);

  logic        r_busy;
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        w_req;

  // Reset kills any outstanding request in the same cycle.
  assign w_req = i_start & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
    end else begin
      r_busy <= w_req & ~i_mem_ack;
      if (w_req && !r_busy) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end
  end

  // First cycle passes the command through; wait cycles replay the captured copy.
  assign o_mem_req   = w_req;
  assign o_mem_we    = w_req & (r_busy ? r_we : i_we);
  assign o_mem_addr  = w_req ? (r_busy ? r_addr : i_addr) : 16'h0000;
  assign o_mem_wdata = w_req ? (r_busy ? r_wdata : i_wdata) : 8'h00;
  assign o_done      = w_req & i_mem_ack;
  assign o_rdata     = i_mem_rdata;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/operand/execute controller: owns the PC, fetches instructions and operands, pulses exec_stb.
// Min 3 cycles per 1-byte instruction; every memory state stalls until mem_ack.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] inst,
  output logic [7:0]  data,
  output logic        dec_en,
  input  logic [15:0] dec_rhs,
  input  logic        dec_inst_halt,
  input  logic        dec_inst_store,
  input  logic        dec_inst_branch,
  input  logic        dec_inst_if,
  input  logic        dec_source_ram,
  input  logic        dec_source_indirect,
  input  logic [15:0] accum,
  input  logic        skip_next,
  output logic [15:0] operand,
  output logic        exec_stb,
  output logic [15:0] pc,
  output logic        halted
);

  seq_state_t  r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_inst, w_inst_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic [15:0] r_addr, w_addr_nxt;
  logic [15:0] r_operand, w_operand_nxt;
  logic        r_skip, w_skip_nxt;

  logic        w_mem_start;
  logic        w_mem_we;
  logic [15:0] w_mem_addr;
  logic [7:0]  w_mem_wdata;
  logic        w_mem_done;
  logic [7:0]  w_mem_rdata;
  logic [15:0] w_ptr_addr;

  cpu_mem_port u_mem_port (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_mem_start),
    .i_we        (w_mem_we),
    .i_addr      (w_mem_addr),
    .i_wdata     (w_mem_wdata),
    .o_done      (w_mem_done),
    .o_rdata     (w_mem_rdata),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack)
  );

  // Pointers live in page zero.
  assign w_ptr_addr = {8'h00, dec_rhs[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH0;
      r_pc      <= RESET_PC;
      r_inst    <= 16'h0000;
      r_data    <= 8'h00;
      r_addr    <= 16'h0000;
      r_operand <= 16'h0000;
      r_skip    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_data    <= w_data_nxt;
      r_addr    <= w_addr_nxt;
      r_operand <= w_operand_nxt;
      r_skip    <= w_skip_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_data_nxt    = r_data;
    w_addr_nxt    = r_addr;
    w_operand_nxt = r_operand;
    w_skip_nxt    = r_skip;
    w_mem_start   = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_addr    = r_pc;
    w_mem_wdata   = 8'h00;
    case (r_state)
      FETCH0: begin
        w_mem_start = 1'b1;
        if (w_mem_done) begin
          w_inst_nxt  = {w_mem_rdata, 8'h00};
          w_pc_nxt    = r_pc + 16'd1;
          w_state_nxt = is_two_byte(w_mem_rdata) ? FETCH1 : DECODE;
        end
      end
      FETCH1: begin
        w_mem_start = 1'b1;
        if (w_mem_done) begin
          w_inst_nxt  = {r_inst[15:8], w_mem_rdata};
          w_pc_nxt    = r_pc + 16'd1;
          w_state_nxt = has_data_byte(r_inst) ? FETCHD : DECODE;
        end
      end
      FETCHD: begin
        w_mem_start = 1'b1;
        if (w_mem_done) begin
          w_data_nxt  = w_mem_rdata;
          w_pc_nxt    = r_pc + 16'd1;
          w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (r_skip) begin
          w_skip_nxt  = 1'b0;
          w_state_nxt = FETCH0;
        end else if (dec_source_indirect) begin
          w_state_nxt = PTR0;
        end else if (dec_source_ram) begin
          w_addr_nxt  = dec_rhs;
          w_state_nxt = RD0;
        end else if (dec_inst_store) begin
          w_state_nxt = WR0;
        end else begin
          w_state_nxt = EXEC;
        end
      end
      PTR0, PTR1: begin
        w_mem_start = 1'b1;
        w_mem_addr  = (r_state == PTR0) ? w_ptr_addr : w_ptr_addr + 16'd1;
        if (w_mem_done) begin
          if (r_state == PTR0) begin
            w_addr_nxt[7:0] = w_mem_rdata;
            w_state_nxt     = PTR1;
          end else begin
            w_addr_nxt[15:8] = w_mem_rdata;
            w_state_nxt      = RD0;
          end
        end
      end
      RD0, RD1: begin
        w_mem_start = 1'b1;
        w_mem_addr  = (r_state == RD0) ? r_addr : r_addr + 16'd1;
        if (w_mem_done) begin
          if (r_state == RD0) begin
            w_operand_nxt[7:0] = w_mem_rdata;
            w_state_nxt        = RD1;
          end else begin
            w_operand_nxt[15:8] = w_mem_rdata;
            w_state_nxt         = EXEC;
          end
        end
      end
      WR0, WR1: begin
        w_mem_start = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = (r_state == WR0) ? dec_rhs : dec_rhs + 16'd1;
        w_mem_wdata = (r_state == WR0) ? accum[7:0] : accum[15:8];
        if (w_mem_done) begin
          w_state_nxt = (r_state == WR0) ? WR1 : EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = FETCH0;
        if (dec_inst_halt) begin
          w_state_nxt = HALT;
        end else if (dec_inst_branch) begin
          w_pc_nxt = r_pc + dec_rhs;
        end else if (dec_inst_if && skip_next) begin
          w_skip_nxt = 1'b1;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = FETCH0;
      end
    endcase
  end

  assign inst     = r_inst;
  assign data     = r_data;
  assign operand  = r_operand;
  assign pc       = r_pc;
  assign exec_stb = (r_state == EXEC);
  assign halted   = (r_state == HALT);
  assign dec_en   = r_state inside {DECODE, PTR0, PTR1, RD0, RD1, WR0, WR1, EXEC};

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a wait-state memory model and a small opcode decoder.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic [15:0] inst, operand, pc, dec_rhs;
  logic [7:0]  data;
  logic        dec_en, exec_stb, halted;
  logic        dec_inst_halt, dec_inst_store, dec_inst_branch, dec_inst_if;
  logic        dec_source_ram, dec_source_indirect;
  logic [15:0] accum = 16'h0000;
  logic        skip_next = 1'b0;

  always #5 clk = ~clk;

  cpu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .inst(inst), .data(data), .dec_en(dec_en), .dec_rhs(dec_rhs),
    .dec_inst_halt(dec_inst_halt), .dec_inst_store(dec_inst_store),
    .dec_inst_branch(dec_inst_branch), .dec_inst_if(dec_inst_if),
    .dec_source_ram(dec_source_ram), .dec_source_indirect(dec_source_indirect),
    .accum(accum), .skip_next(skip_next),
    .operand(operand), .exec_stb(exec_stb), .pc(pc), .halted(halted)
  );

  // Opcodes: 01 HALT, 03 IF, 11xxx branch (11-bit signed offset), 1001 store, 10 src in [10:9].
  assign dec_inst_halt       = dec_en && (inst[15:8] == 8'h01);
  assign dec_inst_if         = dec_en && (inst[15:8] == 8'h03);
  assign dec_inst_branch     = dec_en && (inst[15:14] == 2'b11);
  assign dec_inst_store      = dec_en && (inst[15:12] == 4'b1001);
  assign dec_source_indirect = dec_en && (inst[15:14] == 2'b10) && (inst[10:9] == 2'b10);
  assign dec_source_ram      = dec_en && (inst[15:14] == 2'b10) && (inst[10:9] == 2'b11);
  assign dec_rhs = (inst[15:14] == 2'b11) ? {{5{inst[10]}}, inst[10:0]} : {8'h00, inst[7:0]};

  logic [7:0]  mem [0:65535];
  int          wait_n = 0;
  int          wcnt = 0;
  bit          hold_en = 1'b0;
  logic [15:0] hold_addr = 16'h0000;
  bit          force_ack = 1'b0;
  logic [15:0] log_addr[$];
  bit          log_we[$];
  logic [7:0]  log_wdata[$];

  always @(negedge clk) begin
    if (rst) begin
      log_addr.delete(); log_we.delete(); log_wdata.delete();
      wcnt = 0; mem_ack = force_ack; mem_rdata = 8'h00;
    end else if (mem_req && !(hold_en && mem_addr == hold_addr)) begin
      if (wcnt >= wait_n) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_we ? 8'h00 : mem[mem_addr];
        log_addr.push_back(mem_addr); log_we.push_back(mem_we); log_wdata.push_back(mem_wdata);
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = force_ack;
      wcnt = 0;
    end
  end

  int          cyc, halt_cyc, req_in_halt;
  int          ex_cyc[$];
  logic [15:0] ex_pc[$], ex_inst[$], ex_opnd[$];
  logic [7:0]  ex_data[$];

  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; halt_cyc = 0; req_in_halt = 0;
      ex_cyc.delete(); ex_pc.delete(); ex_inst.delete(); ex_opnd.delete(); ex_data.delete();
    end else begin
      cyc++;
      if (exec_stb) begin
        ex_cyc.push_back(cyc); ex_pc.push_back(pc); ex_inst.push_back(inst);
        ex_opnd.push_back(operand); ex_data.push_back(data);
      end
      if (halted && halt_cyc == 0) halt_cyc = cyc;
      if (halted && mem_req) req_in_halt++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr;
  bit found;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_prog();
    rst = 1'b1;
    foreach (mem[i]) mem[i] = 8'h00;
  endtask

  // Cycle 1 is the first FETCH0 cycle after release.
  task automatic release_and_run(input int ncyc);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_dec_en", dec_en, 1'b0);
    check("rst_exec_stb", exec_stb, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_pc", pc, 16'h0000);
    check("rst_inst", inst, 16'h0000);

    // HALT at 0: FETCH0 c1, DECODE c2, EXEC c3, HALT c4; stray acks while idle are ignored.
    new_prog(); mem[0] = 8'h01;
    release_and_run(8);
    check("t1_halt_cyc", halt_cyc, 4);
    check("t1_exec_cyc", ex_cyc[0], 3);
    check("t1_exec_cnt", ex_cyc.size(), 1);
    check("t1_pc", pc, 16'h0001);
    force_ack = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    force_ack = 1'b0;
    check("t1_req_in_halt", req_in_halt, 0);
    check("t1_still_halted", halted, 1'b1);
    check("t1_pc_after", pc, 16'h0001);
    check("t1_xact_cnt", log_addr.size(), 1);

    // Three-byte data-form instruction, zero wait: F0,F1,FD,DEC,EXEC -> exec on cycle 5.
    new_prog(); mem[0] = 8'h82; mem[1] = 8'h00; mem[2] = 8'h5A; mem[3] = 8'h01;
    release_and_run(12);
    check("t2_inst", ex_inst[0], 16'h8200);
    check("t2_data", ex_data[0], 8'h5A);
    check("t2_pc_at_exec", ex_pc[0], 16'h0003);
    check("t2_exec_cyc", ex_cyc[0], 5);
    check("t2_exec_cnt", ex_cyc.size(), 2);

    // Same with 3 wait states: 3 fetches x 4 cycles, DECODE 13, EXEC 14.
    new_prog(); mem[0] = 8'h82; mem[1] = 8'h00; mem[2] = 8'h5A; mem[3] = 8'h01;
    wait_n = 3;
    release_and_run(30);
    wait_n = 0;
    check("t2w_exec_cyc", ex_cyc[0], 14);
    check("t2w_data", ex_data[0], 8'h5A);
    check("t2w_halted", halted, 1'b1);

    // Store: EF to 0x0010, BE to 0x0011, then exec on cycle 6.
    new_prog(); mem[0] = 8'h90; mem[1] = 8'h10; mem[2] = 8'h01;
    accum = 16'hBEEF;
    release_and_run(12);
    check("t3_wr0_addr", log_addr[2], 16'h0010);
    check("t3_wr0_we", log_we[2], 1'b1);
    check("t3_wr0_data", log_wdata[2], 8'hEF);
    check("t3_wr1_addr", log_addr[3], 16'h0011);
    check("t3_wr1_we", log_we[3], 1'b1);
    check("t3_wr1_data", log_wdata[3], 8'hBE);
    check("t3_next_read", log_we[4], 1'b0);
    check("t3_exec_cyc", ex_cyc[0], 6);

    // Indirect: pointer 0x3000 at 0x20, word 0x1234 at 0x3000.
    new_prog(); mem[0] = 8'h85; mem[1] = 8'h20; mem[2] = 8'h01;
    mem[16'h0020] = 8'h00; mem[16'h0021] = 8'h30; mem[16'h3000] = 8'h34; mem[16'h3001] = 8'h12;
    release_and_run(14);
    check("t4_ptr_lo", log_addr[2], 16'h0020);
    check("t4_ptr_hi", log_addr[3], 16'h0021);
    check("t4_rd_lo", log_addr[4], 16'h3000);
    check("t4_rd_hi", log_addr[5], 16'h3001);
    check("t4_operand", ex_opnd[0], 16'h1234);
    check("t4_exec_cyc", ex_cyc[0], 8);

    // Direct RAM operand at 0x40.
    new_prog(); mem[0] = 8'h86; mem[1] = 8'h40; mem[2] = 8'h01;
    mem[16'h0040] = 8'hCD; mem[16'h0041] = 8'hAB;
    release_and_run(12);
    check("t4r_rd_lo", log_addr[2], 16'h0040);
    check("t4r_rd_hi", log_addr[3], 16'h0041);
    check("t4r_operand", ex_opnd[0], 16'hABCD);

    // Branch 0->0x0100, then C7FE at 0x0100 loops on itself.
    new_prog(); mem[0] = 8'hC0; mem[1] = 8'hFE; mem[16'h0100] = 8'hC7; mem[16'h0101] = 8'hFE;
    release_and_run(14);
    check("t5_first_target", log_addr[2], 16'h0100);
    check("t5_loop_fetch", log_addr[4], 16'h0100);
    check("t5_loop_again", log_addr[6], 16'h0100);
    check("t5_pc_at_exec", ex_pc[1], 16'h0102);

    // PC wrap: branch to 0xFFFD, two NOPs, HALT at 0xFFFF leaves pc at 0.
    new_prog(); mem[0] = 8'hC7; mem[1] = 8'hFB; mem[16'hFFFF] = 8'h01;
    release_and_run(20);
    check("t5w_fetch_fffd", log_addr[2], 16'hFFFD);
    check("t5w_fetch_ffff", log_addr[4], 16'hFFFF);
    check("t5w_halt_cyc", halt_cyc, 14);
    check("t5w_pc", pc, 16'h0000);

    // IF with skip: skipped data-form inst and skipped store are fetched but never executed.
    new_prog();
    mem[0] = 8'h03; mem[1] = 8'h82; mem[2] = 8'h00; mem[3] = 8'h5A;
    mem[4] = 8'h03; mem[5] = 8'h90; mem[6] = 8'h10; mem[7] = 8'h01;
    skip_next = 1'b1;
    release_and_run(22);
    skip_next = 1'b0;
    n_wr = 0;
    foreach (log_we[i]) if (log_we[i]) n_wr++;
    check("t5s_exec_cnt", ex_cyc.size(), 3);
    check("t5s_second_if", ex_inst[1], 16'h0300);
    check("t5s_second_if_cyc", ex_cyc[1], 10);
    check("t5s_halt_cyc", halt_cyc, 17);
    check("t5s_pc", pc, 16'h0008);
    check("t5s_writes", n_wr, 0);
    check("t5s_xact_cnt", log_addr.size(), 8);

    // Reset while RD1 is pending: bus drops immediately, stale ack ignored, restart from RESET_PC.
    new_prog(); mem[0] = 8'h86; mem[1] = 8'h40; mem[2] = 8'h01;
    mem[16'h0040] = 8'hCD; mem[16'h0041] = 8'hAB;
    hold_en = 1'b1; hold_addr = 16'h0041;
    release_and_run(0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_req && mem_addr == 16'h0041) found = 1'b1;
    end
    check("t6_rd1_reached", found, 1'b1);
    check("t6_rd1_dec_en", dec_en, 1'b1);
    rst = 1'b1; force_ack = 1'b1;
    @(posedge clk); #1;
    check("t6_req_dropped", mem_req, 1'b0);
    check("t6_pc", pc, 16'h0000);
    check("t6_dec_en", dec_en, 1'b0);
    check("t6_operand", operand, 16'h0000);
    check("t6_inst", inst, 16'h0000);
    @(posedge clk); #1;
    check("t6_pc_stale_ack", pc, 16'h0000);
    force_ack = 1'b0; hold_en = 1'b0;
    release_and_run(12);
    check("t6_restart_addr", log_addr[0], 16'h0000);
    check("t6_restart_opnd", ex_opnd[0], 16'hABCD);
    check("t6_restart_exec_cyc", ex_cyc[0], 6);
    check("t6_restart_halted", halted, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
